// File: rtl/sample_pair_packer.sv
// Packs a serial row of samples into {odd, even} pairs for the vertical DWT stage,
// extending odd-length lines symmetrically. Optional: SAMPLE_PAIR_PACKER_LENGTH_CHECK_EN.
module sample_pair_packer #(
  parameter  int DataWidth       = 16,
  parameter  int MaximumSideSize = 512,
  localparam int SW              = $clog2(MaximumSideSize)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [SW-1:0]          side_size_i,
  input  logic                   din_valid_i,
  output logic                   din_ready_o,
  input  logic                   din_eol_i,
  input  logic [DataWidth-1:0]   din_i,
  output logic                   dout_valid_o,
  input  logic                   dout_ready_i,
  output logic                   dout_eol_o,
  output logic [2*DataWidth-1:0] dout_o,
  output logic                   err_o
);

  typedef enum logic {EVEN = 1'b0, ODD = 1'b1} state_t;

  state_t                 state_r;
  logic [SW-1:0]          col_r;
  logic [SW-1:0]          n_r;
  logic [DataWidth-1:0]   even_r;
  logic [DataWidth-1:0]   prev_odd_r;
  logic                   dout_valid_r;
  logic                   dout_eol_r;
  logic [2*DataWidth-1:0] dout_r;

  logic [SW-1:0] n_cur_s;
  logic          last_s;
  logic          out_free_s;
  logic          din_ready_s;
  logic          accept_s;
  logic          load_s;

  function automatic logic [SW-1:0] clamp_side(input logic [SW-1:0] side);
    if (side < SW'(2)) begin
      return SW'(2);
    end else begin
      return side;
    end
  endfunction

  // Line length in force for the current sample, handshake and pair-load decode
  always_comb begin
    n_cur_s     = n_r;
    last_s      = 1'b0;
    out_free_s  = 1'b0;
    din_ready_s = 1'b1;
    accept_s    = 1'b0;
    load_s      = 1'b0;
    // Line length is only sampled at column 0 so mid-line changes are ignored
    if (col_r == SW'(0)) begin
      n_cur_s = clamp_side(side_size_i);
    end else begin
      n_cur_s = n_r;
    end
    last_s     = (col_r == (n_cur_s - SW'(1)));
    out_free_s = !dout_valid_r || dout_ready_i;
    if ((state_r == ODD) || last_s) begin
      din_ready_s = out_free_s;
    end else begin
      din_ready_s = 1'b1;
    end
    accept_s = din_valid_i && din_ready_s;
    load_s   = accept_s && ((state_r == ODD) || last_s);
  end

  // Framing state, sample holding registers and the output pair register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= EVEN;
      col_r        <= SW'(0);
      n_r          <= SW'(2);
      even_r       <= '0;
      prev_odd_r   <= '0;
      dout_valid_r <= 1'b0;
      dout_eol_r   <= 1'b0;
      dout_r       <= '0;
    end else begin
      if (accept_s) begin
        if (col_r == SW'(0)) begin
          n_r <= n_cur_s;
        end
        col_r <= last_s ? SW'(0) : (col_r + SW'(1));
        case (state_r)
          EVEN: begin
            // The last sample of an odd line pairs with prev_odd and stays in EVEN
            if (!last_s) begin
              even_r  <= din_i;
              state_r <= ODD;
            end
          end
          ODD: begin
            prev_odd_r <= din_i;
            state_r    <= EVEN;
          end
          default: state_r <= EVEN;
        endcase
      end
      if (load_s) begin
        dout_valid_r <= 1'b1;
        dout_eol_r   <= last_s;
        dout_r       <= (state_r == ODD) ? {din_i, even_r} : {prev_odd_r, din_i};
      end else if (dout_valid_r && dout_ready_i) begin
        dout_valid_r <= 1'b0;
      end
    end
  end

`ifdef SAMPLE_PAIR_PACKER_LENGTH_CHECK_EN
  logic err_r;

  // Sticky flag: upstream end-of-line marker disagrees with the local column count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_r <= 1'b0;
    end else if (accept_s && (din_eol_i != last_s)) begin
      err_r <= 1'b1;
    end
  end

  assign err_o = err_r;
`else
  logic unused_eol_s;
  assign unused_eol_s = din_eol_i;
  assign err_o        = 1'b0;
`endif

  assign din_ready_o  = din_ready_s;
  assign dout_valid_o = dout_valid_r;
  assign dout_eol_o   = dout_eol_r;
  assign dout_o       = dout_r;

endmodule

// File: doc/sample_pair_packer.md
SAMPLE_PAIR_PACKER -- requirements
Module: sample_pair_packer

Interface
REQ-001 Parameter DataWidth, default 16, width of one sample.
REQ-002 Parameter MaximumSideSize, default 512, upper bound on line length; SW = $clog2(MaximumSideSize).
REQ-003 clk_i  input  1  single clock; all state on rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 side_size_i  input  SW  line length N in samples; values below 2 are treated as 2.
REQ-006 din_valid_i  input  1  input sample valid.
REQ-007 din_ready_o  output  1  input sample accepted when din_valid_i && din_ready_o.
REQ-008 din_eol_i  input  1  upstream end-of-line marker; only checked, never controls framing.
REQ-009 din_i  input  DataWidth  serial sample, row order.
REQ-010 dout_valid_o  output  1  packed pair valid.
REQ-011 dout_ready_i  input  1  downstream (VerticalDwt) ready.
REQ-012 dout_eol_o  output  1  high on the last pair of a line.
REQ-013 dout_o  output  2*DataWidth  [DataWidth-1:0] = even sample, [2*DataWidth-1:DataWidth] = odd sample.
REQ-014 err_o  output  1  sticky line-length mismatch flag (see Configuration).

Function
REQ-015 Two-state FSM: EVEN (waiting for sample at even column) and ODD (even sample held, waiting for odd sample).
REQ-016 Column counter col (SW bits) counts accepted samples in the current line; resets to 0 after the last sample of a line.
REQ-017 side_size_i is latched into N when the col==0 sample is accepted; changes mid-line have no effect until the next line.
REQ-018 In EVEN, a non-last accepted sample is stored in the even register; FSM -> ODD; no output produced; din_ready_o=1 regardless of output state.
REQ-019 In ODD, din_ready_o = !dout_valid_o || dout_ready_i; on accept, the pair {din_i, even} is loaded into the output register; FSM -> EVEN.
REQ-020 The accepted odd sample is also kept as prev_odd for odd-length extension.
REQ-021 Odd N: the last sample (col==N-1, even position) is accepted only when the ODD-state ready condition holds; the pair {prev_odd, din_i} (whole-sample symmetric extension x[N]=x[N-2]) is loaded; FSM stays EVEN.
REQ-022 dout_eol_o is set with the pair containing sample col==N-1, cleared with any other pair.
REQ-023 Latency: a pair is visible on dout_o the cycle after its completing sample is accepted; sustained throughput is one pair per two input samples with no bubbles.
REQ-024 dout_valid_o clears on dout_valid_o && dout_ready_i unless a new pair is loaded in the same cycle; dout_o, dout_eol_o stable while dout_valid_o && !dout_ready_i.
REQ-025 Simultaneous output handshake and new pair load in one cycle: the new pair replaces the old; dout_valid_o stays 1.

Reset
REQ-026 On rst_ni low: FSM=EVEN, col=0, N=2, even/prev_odd=0, dout_valid_o=0, dout_eol_o=0, dout_o=0, err_o=0; din_ready_o=1 when reset is released.
REQ-027 Reset mid-line discards any partial pair and the pending output; the next accepted sample is column 0 of a new line.

Configuration
REQ-028 Macro SAMPLE_PAIR_PACKER_LENGTH_CHECK_EN defined: err_o sets (sticky until reset) when an accepted sample has din_eol_i != (col==N-1).
REQ-029 Macro undefined: comparison logic is absent, err_o is constant 0; din_eol_i is ignored.

Verification
REQ-030 N=4, samples 1,2,3,4, dout_ready_i=1 -> dout_o {2,1} eol=0 then {4,3} eol=1.
REQ-031 N=5, samples 1..5 -> {2,1}, {4,3}, then {4,5} (odd=4, even=5) with eol=1; next line starts at column 0.
REQ-032 N=4, dout_ready_i=0 after first pair -> {2,1} held stable; sample 3 accepted, sample 4 stalled (din_ready_o=0) until ready returns, then {4,3}.
REQ-033 rst_ni pulsed low after samples 1,2,3 of an N=6 line -> dout_valid_o=0, err_o=0; new samples 7,8 -> {8,7} eol=0.
REQ-034 With SAMPLE_PAIR_PACKER_LENGTH_CHECK_EN, N=4, din_eol_i high on sample 3 -> err_o=1 from next cycle, framing unchanged ({4,3} eol=1); without macro err_o stays 0.
